// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if -- receive-side handshake bundle of the parametrised UART
// receiver.
//   rdata  : FIFO head data word
//   rferr  : FIFO head framing error flag
//   rperr  : FIFO head parity error flag
//   rbrk   : FIFO head break flag
//   rvalid : FIFO holds at least one entry
//   rready : consumer accepts the head entry when rvalid is high
// modport master : receiver side (drives the head entry and rvalid)
// modport slave  : consumer side (drives rready)
`timescale 1ns/1ps
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rdata;
  logic                 rferr;
  logic                 rperr;
  logic                 rbrk;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output rdata,
    output rferr,
    output rperr,
    output rbrk,
    output rvalid,
    input  rready
  );

  modport slave (
    input  rdata,
    input  rferr,
    input  rperr,
    input  rbrk,
    input  rvalid,
    output rready
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver with 3-sample majority voting,
// false-start rejection, parity/framing/break detection and a small receive
// FIFO drained over a valid/ready handshake.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   rxd_i      : asynchronous serial line, idle high
//   clr_ovr_i  : clears the sticky overrun flag
//   overrun_o  : sticky, a completed frame was dropped on a full FIFO
//   busy_o     : receiver state machine is not idle
//   rx_if      : master side of the receive handshake (head entry, rvalid, rready)
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLK_PER_BIT = 10416,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd_i,
  input  logic            clr_ovr_i,
  output logic            overrun_o,
  output logic            busy_o,
  uart_rx_param_if.master rx_if
);

  localparam int M  = CLK_PER_BIT / 2;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 3;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(M - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(M);
  localparam logic [CW-1:0] SAMP_C   = CW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Input synchroniser and edge detector
  logic sync1_q, rxs_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd_i;
      rxs_q     <= sync1_q;
      rx_prev_q <= rxs_q;
    end
  end

  // Bit timer and majority voter
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    samp_q;
  logic          in_frame;
  logic          decide;
  logic          maj;

  assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign decide   = in_frame && (cnt_q == SAMP_C);
  // Third sample is the live synchronised value at the decision count.
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

  // Held at zero while idle so the count starts at 0 on entry to START;
  // free-running modulo CLK_PER_BIT for the rest of the frame.
  always_comb begin
    cnt_d = '0;
    if (in_frame) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      samp_q <= 2'b11;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == SAMP_A) samp_q[0] <= rxs_q;
      if (cnt_q == SAMP_B) samp_q[1] <= rxs_q;
    end
  end

  // Frame datapath
  logic [DATA_BITS-1:0] shreg_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 par_bit_q;
  logic                 perr_q;
  logic                 ferr_acc_q;
  logic                 last_stop;
  logic                 is_break;
  logic                 frame_done;
  logic                 par_xor;

  assign last_stop  = (stop_cnt_q == STOP_LAST);
  // Break only looks at the first stop bit; a second one is never sampled.
  assign is_break   = (shreg_q == '0) && ((PARITY == 0) || !par_bit_q) &&
                      !maj && !stop_cnt_q;
  assign frame_done = (state_q == S_STOP) && decide && (is_break || last_stop);
  assign par_xor    = (^shreg_q) ^ maj;

  // Completed frame is staged here and written into the FIFO one cycle later.
  logic                 push_q;
  logic [EW-1:0]        entry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_acc_q <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
    end else begin
      push_q <= frame_done;
      if (frame_done) begin
        entry_q <= {shreg_q, (ferr_acc_q | ~maj), perr_q, is_break};
      end
      if (decide) begin
        case (state_q)
          S_START: begin
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_acc_q <= 1'b0;
          end
          S_DATA: begin
            shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
          S_PARITY: begin
            par_bit_q <= maj;
            // odd: error unless data^p == 1; even: error unless data^p == 0
            perr_q    <= (PARITY == 1) ? ~par_xor : par_xor;
          end
          S_STOP: begin
            if (!maj) ferr_acc_q <= 1'b1;
            stop_cnt_q <= ~stop_cnt_q;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q && rx_prev_q) state_d = S_START;
      end
      S_START: begin
        if (decide) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide && (bit_cnt_q == BIT_LAST)) begin
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          if (is_break)       state_d = S_WAIT_HIGH;
          else if (last_stop) state_d = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          fifo_valid;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [EW-1:0] head;

  assign fifo_valid = (count_q != '0);
  assign do_pop     = fifo_valid && rx_if.rready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign do_push    = push_q && ((count_q != FIFO_FULL) || do_pop);
  assign drop       = push_q && (count_q == FIFO_FULL) && !do_pop;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Drop takes priority over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (drop)           overrun_d = 1'b1;
    else if (clr_ovr_i) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= entry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FSM / FIFO: output logic. Head fields are gated so an empty FIFO shows zeros.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    overrun_o    = overrun_q;
    rx_if.rvalid = fifo_valid;
    rx_if.rdata  = fifo_valid ? head[EW-1:3] : '0;
    rx_if.rferr  = fifo_valid & head[2];
    rx_if.rperr  = fifo_valid & head[1];
    rx_if.rbrk   = fifo_valid & head[0];
  end

endmodule
